data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 74 +++++++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

  // Request lifecycle: waiting for a request, counting wait states, acknowledging.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // funct3 access size / signedness encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 9;
  // Wait counter width: WAIT_CYCLES is limited to 0..7.
  localparam int CNT_W          = 3;

  // Number of words addressed by a byte address of width addr_w.
  function automatic int dmem_depth(input int addr_w);
    return 2 ** (addr_w - 2);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and shifted write data for stores,
// lane selection plus sign/zero extension for loads, and request legality.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]               funct3_i,
  input  logic [1:0]               addr_lo_i,
  input  logic                     is_wr_i,
  input  logic                     is_rd_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [DATA_W-1:0]        rd_word_i,
  output logic [DATA_W/BYTE_W-1:0] byte_en_o,
  output logic [DATA_W-1:0]        wr_word_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     err_o
);

  localparam int NB = DATA_W / BYTE_W;

  logic [4:0]        shift;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_val;
  logic [NB-1:0]     be_base;
  logic              size_ok;
  logic              load_only;
  logic              misalign;
  logic              req_err;

  // Decode size, check legality/alignment, and steer data to/from the addressed lane.
  always_comb begin
    shift     = {addr_lo_i, 3'b000};
    rd_shift  = rd_word_i >> shift;
    ld_val    = '0;
    be_base   = '0;
    size_ok   = 1'b1;
    load_only = 1'b0;
    misalign  = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_base = NB'(1);
        ld_val  = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      end
      F3_H: begin
        be_base  = NB'(3);
        misalign = addr_lo_i[0];
        ld_val   = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      end
      F3_W: begin
        be_base  = NB'(15);
        misalign = (addr_lo_i != 2'b00);
        ld_val   = rd_shift;
      end
      F3_BU: begin
        load_only = 1'b1;
        ld_val    = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
      end
      F3_HU: begin
        load_only = 1'b1;
        misalign  = addr_lo_i[0];
        ld_val    = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
      end
      default: size_ok = 1'b0;
    endcase
    // Both strobes at once is ambiguous, so it is rejected like any illegal request.
    req_err   = (is_wr_i && is_rd_i) || !size_ok || (is_wr_i && load_only) || misalign;
    err_o     = req_err;
    byte_en_o = (req_err || !is_wr_i) ? '0 : (be_base << addr_lo_i);
    wr_word_o = wr_data_i << shift;
    rd_data_o = (req_err || !is_rd_i) ? '0 : ld_val;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte/half/word access, programmable wait
// states, and a single-outstanding-request ack/err handshake.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = dmem_depth(ADDR_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         f3_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               wr_q;
  logic               rd_q;
  logic               err_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               accept;
  logic               access;

  logic [NB-1:0]      byte_en;
  logic [DATA_W-1:0]  wr_word;
  logic [DATA_W-1:0]  ld_data;
  logic [DATA_W-1:0]  rd_word;
  logic               align_err;

  // Contents are never reset; they survive reset and are unknown until written.
  logic [DATA_W-1:0]  mem_q [DEPTH];

  assign rd_word = mem_q[addr_q[ADDR_W-1:2]];

  dmem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .is_wr_i   (wr_q),
    .is_rd_i   (rd_q),
    .wr_data_i (wdata_q),
    .rd_word_i (rd_word),
    .byte_en_o (byte_en),
    .wr_word_o (wr_word),
    .rd_data_o (ld_data),
    .err_o     (align_err)
  );

  // Next-state logic: accept in IDLE, count down wait states, perform access when counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd || wr) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, latched request and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        f3_q    <= funct3;
        wdata_q <= wr_data;
        wr_q    <= wr;
        rd_q    <= rd;
      end
      if (access) begin
        err_q     <= align_err;
        rd_data_q <= ld_data;
      end
    end
  end

  // Byte-lane write at the access edge; byte_en is already zero for loads and failed requests.
  always_ff @(posedge clk) begin
    if (access) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem_q[addr_q[ADDR_W-1:2]][i*BYTE_W +: BYTE_W] <= wr_word[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign ack     = (state_q == ST_RESP);
  assign err     = ack && err_q;
  assign rd_data = rd_data_q;

endmodule
